// File: rtl/dbd_pkg.sv
// Shared types, field constants and the sanitizing helper for data_bus_driver.
package dbd_pkg;

  typedef logic [31:0] word_t;

  localparam int         CHK_LSB     = 5;
  localparam int         CHK_MSB     = 6;
  localparam logic [1:0] ILLEGAL_VAL = 2'b11;
  localparam logic [1:0] COERCE_VAL  = 2'b10;

  function automatic logic is_illegal(input word_t w);
    return (w[CHK_MSB:CHK_LSB] == ILLEGAL_VAL);
  endfunction

  // Only the checked field is touched; every other bit passes through.
  function automatic word_t sanitize(input word_t w);
    word_t r;
    r = w;
    if (is_illegal(w)) r[CHK_MSB:CHK_LSB] = COERCE_VAL;
    return r;
  endfunction

endpackage

// File: rtl/dbd_fifo.sv
// Power-of-two FIFO: registered storage, wrapping pointers and occupancy count.
// Callers must only push when not full and only pop when not empty.
module dbd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/data_bus_driver.sv
// Upstream bus producer: buffers words, forces field [6:5] away from 2'b11 and
// tracks illegal words. Define DBD_DROP_ILLEGAL_EN to discard illegal words instead.
//
// Handshakes: a word moves on a posedge only when its valid and ready are both
// high; ready/valid derive solely from the registered count, never from the peer.
module data_bus_driver
  import dbd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            data_bus,
  output logic [31:0]            bus_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       illegal_cnt,
  output logic                   illegal_seen
);

  localparam int                CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);

  logic       w_push_hs;
  logic       w_store;
  logic       w_pop;
  logic       w_illegal;
  word_t      w_clean;
  word_t      w_head;

  logic [CNT_W-1:0] r_illegal_cnt;
  logic             r_illegal_seen;
  word_t            r_bus_data;

  assign in_ready  = (fifo_count != FULL_CNT);
  assign out_valid = (fifo_count != '0);
  assign w_push_hs = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_illegal = is_illegal(in_data);
  assign w_clean   = sanitize(in_data);

`ifdef DBD_DROP_ILLEGAL_EN
  // Illegal words are still acknowledged upstream, they just never enter storage.
  assign w_store = w_push_hs && !w_illegal;
`else
  assign w_store = w_push_hs;
`endif

  dbd_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_store),
    .i_data  (w_clean),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (fifo_count)
  );

  // Stale storage stays hidden while empty so data_bus never shows 2'b11.
  assign data_bus = out_valid ? w_head : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_data     <= '0;
      r_illegal_cnt  <= '0;
      r_illegal_seen <= 1'b0;
    end else begin
      if (w_pop) r_bus_data <= data_bus;
      if (w_push_hs && w_illegal) begin
        r_illegal_seen <= 1'b1;
        if (r_illegal_cnt != '1) r_illegal_cnt <= r_illegal_cnt + 1'b1;
      end
    end
  end

  assign bus_data     = r_bus_data;
  assign illegal_cnt  = r_illegal_cnt;
  assign illegal_seen = r_illegal_seen;

endmodule
